// File: rtl/lab4_net_ring_out_sched.sv
// lab4_net_ring_out_sched
//   Output scheduler and credit tracker for one ring-network router.
//   It routes the head messages of the terminal, prev and next input queues
//   to the forward, backward and terminal outputs. Each output uses a 1-bit
//   round-robin arbiter. Forward and backward downstream credits are tracked,
//   and the counts break direction ties for injected half-ring traffic.
// Ports:
//   clk, reset (async, active-low)
//   {term,prev,next}_req_val/_dest  : input queue heads
//   term_out_rdy                    : terminal sink ready
//   forw_credit_ret/backw_credit_ret: downstream entry freed
//   {term,prev,next}_grant          : dequeue the head of that input
//   {forw,backw,term}_send/_sel     : output transfer and its source (0 term, 1 prev, 2 next)
//   forw_free/backw_free            : current free credits
//   credit_err                      : sticky credit-overflow flag
module lab4_net_ring_out_sched #(
    parameter int unsigned p_srcdest_nbits = 3,
    parameter int unsigned p_router_id     = 0,
    parameter int unsigned p_num_routers   = 8,
    parameter int unsigned p_num_entries   = 2,
    parameter int unsigned f               = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       term_req_val,
    input  logic [p_srcdest_nbits-1:0] term_req_dest,
    input  logic                       prev_req_val,
    input  logic [p_srcdest_nbits-1:0] prev_req_dest,
    input  logic                       next_req_val,
    input  logic [p_srcdest_nbits-1:0] next_req_dest,
    input  logic                       term_out_rdy,
    input  logic                       forw_credit_ret,
    input  logic                       backw_credit_ret,
    output logic                       term_grant,
    output logic                       prev_grant,
    output logic                       next_grant,
    output logic                       forw_send,
    output logic                       backw_send,
    output logic                       term_send,
    output logic [1:0]                 forw_sel,
    output logic [1:0]                 backw_sel,
    output logic [1:0]                 term_sel,
    output logic [f-1:0]               forw_free,
    output logic [f-1:0]               backw_free,
    output logic                       credit_err
);

    localparam int unsigned S = p_srcdest_nbits;
    localparam logic [S-1:0] ID   = S'(p_router_id);
    localparam logic [S:0]   ID_W = (S+1)'(p_router_id);
    localparam logic [S:0]   N_W  = (S+1)'(p_num_routers);
    localparam logic [f-1:0] MAX  = f'(p_num_entries);

    // Round-robin pointers: 1 favours the second candidate of the pair.
    // forward {term, prev}, backward {term, next}, terminal {prev, next}
    logic ptr_forw, ptr_backw, ptr_term;

    logic [S:0] dest_w, dist_f, dist_b;
    logic       term_to_term, term_to_forw;
    logic       forw_ok, backw_ok, term_ok;
    logic       fa, fb, ba, bb, ta, tb;
    logic       gfa, gfb, gba, gbb, gta, gtb;

    always_comb begin
        dest_w = {1'b0, term_req_dest};
        dist_f = (dest_w >= ID_W) ? (dest_w - ID_W) : (dest_w + N_W - ID_W);
        dist_b = N_W - dist_f;
        term_to_term = (term_req_dest == ID);
        // Half-ring tie goes to the emptier direction, forward on equal counts.
        term_to_forw = !term_to_term &&
                       ((dist_f < dist_b) ||
                        ((dist_f == dist_b) && (forw_free >= backw_free)));

        // Gating with reset forces every grant low while reset is held.
        forw_ok  = reset && (forw_free != '0);
        backw_ok = reset && (backw_free != '0);
        term_ok  = reset && term_out_rdy;

        fa = term_req_val && term_to_forw && forw_ok;
        fb = prev_req_val && (prev_req_dest != ID) && forw_ok;
        ba = term_req_val && !term_to_term && !term_to_forw && backw_ok;
        bb = next_req_val && (next_req_dest != ID) && backw_ok;
        ta = prev_req_val && (prev_req_dest == ID) && term_ok;
        tb = next_req_val && (next_req_dest == ID) && term_ok;

        gfa = fa && (!fb || !ptr_forw);
        gfb = fb && (!fa || ptr_forw);
        gba = ba && (!bb || !ptr_backw);
        gbb = bb && (!ba || ptr_backw);
        gta = ta && (!tb || !ptr_term);
        gtb = tb && (!ta || ptr_term);

        term_grant = gfa || gba;
        prev_grant = gfb || gta;
        next_grant = gbb || gtb;

        forw_send  = gfa || gfb;
        backw_send = gba || gbb;
        term_send  = gta || gtb;

        forw_sel  = gfb ? 2'd1 : 2'd0;
        backw_sel = gbb ? 2'd2 : 2'd0;
        term_sel  = gta ? 2'd1 : (gtb ? 2'd2 : 2'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_forw   <= 1'b1;
            ptr_backw  <= 1'b1;
            ptr_term   <= 1'b0;
            forw_free  <= MAX;
            backw_free <= MAX;
            credit_err <= 1'b0;
        end else begin
            // Pointer flips only when the favoured requester wins.
            ptr_forw  <= ptr_forw  ? !gfb : gfa;
            ptr_backw <= ptr_backw ? !gbb : gba;
            ptr_term  <= ptr_term  ? !gtb : gta;

            case ({forw_send, forw_credit_ret})
                2'b10:   forw_free <= forw_free - 1'b1;
                2'b01: begin
                    if (forw_free == MAX) credit_err <= 1'b1;
                    else                  forw_free  <= forw_free + 1'b1;
                end
                default: ;
            endcase

            case ({backw_send, backw_credit_ret})
                2'b10:   backw_free <= backw_free - 1'b1;
                2'b01: begin
                    if (backw_free == MAX) credit_err <= 1'b1;
                    else                   backw_free <= backw_free + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lab4_net_ring_out_sched.md
# lab4_net_ring_out_sched

Output scheduler and credit tracker for one ring-network router. Each cycle it routes the head messages of the three router input queues (terminal injection, from-previous, from-next) to the three outputs (forward, backward, terminal). It arbitrates round-robin per output and tracks downstream free-entry credits on both ring channels. Its free counts drive the router's congestion outputs, and they choose the direction for injected messages that are exactly half a ring away.

## Interface
- p_srcdest_nbits (s), 3: width of destination ids; p_num_routers <= 2^s.
- p_router_id, 0: id of this router.
- p_num_routers, 8: routers on the ring; must be even and >= 2.
- p_num_entries, 2: depth of each downstream ring input queue, which is also the initial credit.
- f, 2: width of the free counts; holds 0..p_num_entries.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- term_req_val, term_req_dest  input  1, s  head of the injection queue is valid, and its destination.
- prev_req_val, prev_req_dest  input  1, s  head of the queue from the previous router (travels forward).
- next_req_val, next_req_dest  input  1, s  head of the queue from the next router (travels backward).
- term_out_rdy  input  1  terminal sink can accept a message.
- forw_credit_ret, backw_credit_ret  input  1  downstream queue freed one entry.
- term_grant, prev_grant, next_grant  output  1  dequeue the head of this input this cycle.
- forw_send, backw_send, term_send  output  1  output transfers a message this cycle.
- forw_sel, backw_sel, term_sel  output  2  source of the output: 0 = term, 1 = prev, 2 = next.
- forw_free, backw_free  output  f  current free credits.
- credit_err  output  1  sticky flag: a credit was returned while the counter was already full.

## Operation
- Route computation is combinational per requester.
  - A request with dest == p_router_id goes to the terminal output.
  - Otherwise, prev goes forward and next goes backward.
  - For term, compute dist_f = (dest - id) mod N in s+1 bits (dest >= id ? dest-id : dest+N-id), and dist_b = N - dist_f.
  - dist_f < dist_b goes forward; dist_f > dist_b goes backward.
  - When dist_f == dist_b, the direction with the larger free count is chosen; a tie goes forward.
  - Term routing is re-evaluated every cycle until the request is granted; no decision is latched.
- Candidate sets per output: forward {term, prev}; backward {term, next}; terminal {prev, next}.
  - Each input targets exactly one output, so an input never gets two grants.
- Eligibility:
  - Forward requires forw_free > 0.
  - Backward requires backw_free > 0.
  - Terminal requires term_out_rdy.
- Per-output arbitration is round-robin between two requesters using a 1-bit priority pointer.
  - The pointer moves to the other requester only when a grant is issued to the requester it currently points at.
  - A lone requester is granted regardless of pointer value, and the pointer updates by the same rule.
- X_send = grant issued on output X. X_sel = the granted source; X_sel is 0 when not sending.
- Credit counters: free_next = free - send + ret.
  - Send and return in the same cycle leave the count unchanged.
  - A return at free == p_num_entries with no send holds the count at max and sets credit_err.
  - The count never goes below 0, because send requires free > 0.
- Reset values:
  - forw_free = backw_free = p_num_entries.
  - credit_err = 0.
  - Forward pointer favours prev, backward pointer favours next, terminal pointer favours prev.
  - All grant, send and sel outputs are forced to 0 while reset is low.

## Timing
- Grants, sends and sels are combinational from the current requests and state, so the grant appears in the same cycle as the request.
- The counter decrement from a send is visible on forw_free/backw_free the cycle after the send.
- A credit return is usable for a grant the cycle after ret is asserted. Return-to-use latency is 1 cycle.
- Pointer updates take effect at the next rising edge.
- Asserting reset mid-operation immediately zeroes grants and restores the counters and pointers without waiting for clk. Credits in flight are discarded.
- Deasserting reset: the first grants may occur in the first cycle after release.

## Test plan
- Reset release, no requests -> forw_free = backw_free = 2, all grants/sends 0, credit_err = 0.
- id = 0, N = 8, term dest 3 -> same cycle: term_grant = 1, forw_send = 1, forw_sel = 0; next cycle forw_free = 1.
- Drain forward with two term sends to dest 2, no returns (forw_free = 0), then term dest 4 -> backw_send = 1, backw_sel = 0, term_grant = 1.
- prev and term both request forward for 4 cycles with credits returned each cycle -> grants alternate prev, term, prev, term.
- forw_free = 0, prev requesting -> no grant. Pulse forw_credit_ret -> next cycle forw_free = 1 and prev_grant = 1.
- Credit corner cases:
  - free = 1 with send and ret in the same cycle -> stays 1.
  - ret at free = 2 -> stays 2 and credit_err = 1.
  - Assert reset mid-stream -> grants 0 immediately, free = 2, credit_err = 0.
